// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state encoding,
// stream framing constants and a small state-classification helper.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HEADER_BYTES   = 2;

    // States in which the loader owns the stream and accepts bytes.
    function automatic logic is_active(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Shift-in packer: collects BYTES_PER_WORD bytes MSB-first and presents the full
// big-endian word combinationally alongside the final byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  rx_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] partial;
    logic [1:0]  count;

    always_ff @(posedge clk) begin
        if (clear) begin
            partial <= '0;
            count   <= '0;
        end else if (shift) begin
            partial <= {partial[15:0], rx_byte};
            count   <= count + 2'd1;
        end
    end

    // The last byte bypasses the register so the word can be written on its own edge.
    assign word_valid = shift && (count == 2'(BYTES_PER_WORD - 1));
    assign word       = {partial, rx_byte};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed big-endian byte stream, writes words to IM at
// 0..N-1 and releases the CPU reset afterwards. Trailer checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = HEADER_BYTES * 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
    logic [7:0] csum;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t           state, next_state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len, word_cnt, len_rx;
    logic             xfer, start_ok, too_big, last_word;
    logic             word_valid;
    logic [31:0]      word;
    logic             ready_nxt, busy_nxt, done_nxt, err_nxt;

    assign xfer      = rx_valid && rx_ready;
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_rx    = LEN_W'({len_hi, rx_data});
    assign too_big   = {1'b0, len_rx} > CAPACITY;
    assign last_word = word_valid && (word_cnt == len - LEN_W'(1));

    byte_packer u_packer (
        .clk        (clk),
        .clear      (!rst_n || start_ok),
        .shift      (xfer && (state == DATA)),
        .rx_byte    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = LEN_HI;
            LEN_HI:          if (xfer) next_state = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (too_big)              next_state = ERR;
                    else if (len_rx == '0)    next_state = AFTER_DATA;
                    else                      next_state = DATA;
                end
            end
            DATA:            if (last_word) next_state = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:             if (xfer) next_state = (rx_data == csum) ? DONE : ERR;
`endif
            default:         next_state = IDLE;
        endcase
    end

    // Leaving DATA for DONE delays done/cpu_rst_n by one cycle so they trail the final write.
    always_comb begin
        ready_nxt = is_active(next_state);
        busy_nxt  = is_active(next_state);
        done_nxt  = (next_state == DONE) && (state != DATA);
        err_nxt   = (next_state == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
            err       <= 1'b0;
            im_we     <= 1'b0;
            im_waddr  <= '0;
            im_wdata  <= '0;
        end else begin
            rx_ready  <= ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cpu_rst_n <= done_nxt;
            err       <= err_nxt;
            im_we     <= word_valid;
            if (word_valid) begin
                im_waddr <= word_cnt[ADDR_W-1:0];
                im_wdata <= word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_hi   <= '0;
            len      <= '0;
            word_cnt <= '0;
        end else begin
            if (xfer && (state == LEN_HI)) len_hi <= rx_data;
            if (xfer && (state == LEN_LO)) begin
                len      <= len_rx;
                word_cnt <= '0;
            end
            if (word_valid) word_cnt <= word_cnt + LEN_W'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over header and payload; the trailer itself is not folded in.
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            csum <= '0;
        end else if (xfer && ((state == LEN_HI) || (state == LEN_LO) || (state == DATA))) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule
